// File: rtl/spiram_arbiter_pkg.sv
// Shared encodings and defaults for the two-port SPI RAM arbiter.
package spiram_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int DEF_START_TIMEOUT = 8;
    localparam int DEF_DONE_TIMEOUT  = 4095;

endpackage

// File: rtl/spiram_rr_arb2.sv
// Two-way grant select: round-robin on last_grant, or fixed p0 priority.
// Latency: combinational.
// Backpressure: none; the caller samples the grant only when it can accept one.
module spiram_rr_arb2
    import spiram_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_vld,
    output logic gnt_id
);

    always_comb begin
        gnt_vld = req0 | req1;
        gnt_id  = PORT_CPU;
        if (req0 && req1) begin
            gnt_id = (FIXED_PRIO != 0) ? PORT_CPU : ~last_grant;
        end else if (req1) begin
            gnt_id = PORT_AUX;
        end
    end

endmodule

// File: rtl/spiram_arbiter.sv
// Serialises two word-request ports onto the SPI RAM controller rd/wr strobes.
// Latency: ack 4 cycles plus controller busy time after req is sampled.
// Backpressure: req is level-held until ack; losing port simply waits.
module spiram_arbiter
    import spiram_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO    = 0,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int DONE_TIMEOUT  = DEF_DONE_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [15:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [15:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rbusy,
    input  logic        mem_wbusy,
    output logic        grant_id
);

    localparam int            CW        = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CW-1:0] START_MAX = CW'(START_TIMEOUT);
    localparam logic [CW-1:0] DONE_MAX  = CW'(DONE_TIMEOUT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          last_grant_q, last_grant_d;
    logic          grant_id_q, grant_id_d;
    logic          we_q, we_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
    logic          p0_err_q, p0_err_d, p1_err_q, p1_err_d;
    logic [31:0]   p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

    logic          gnt_vld, gnt_id;
    logic          sel_we;
    logic [15:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic          busy;
    logic          rsp_fire, rsp_err, rsp_cap;

    spiram_rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .req0       (p0_req),
        .req1       (p1_req),
        .last_grant (last_grant_q),
        .gnt_vld    (gnt_vld),
        .gnt_id     (gnt_id)
    );

    assign sel_we    = (gnt_id == PORT_AUX) ? p1_we    : p0_we;
    assign sel_addr  = (gnt_id == PORT_AUX) ? p1_addr  : p0_addr;
    assign sel_wdata = (gnt_id == PORT_AUX) ? p1_wdata : p0_wdata;
    assign busy      = mem_rbusy | mem_wbusy;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        we_d         = we_q;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        p0_ack_d     = 1'b0;
        p1_ack_d     = 1'b0;
        p0_err_d     = 1'b0;
        p1_err_d     = 1'b0;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        rsp_fire     = 1'b0;
        rsp_err      = 1'b0;
        rsp_cap      = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    grant_id_d   = gnt_id;
                    last_grant_d = gnt_id;
                    we_d         = sel_we;
                    mem_addr_d   = sel_addr;
                    mem_wdata_d  = sel_wdata;
                    mem_rd_d     = ~sel_we;
                    mem_wr_d     = sel_we;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A busy flag still high from the previous op counts as the rise.
                if (busy) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == START_MAX) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    rsp_fire = 1'b1;
                    rsp_cap  = ~we_q;
                end else if (cnt_q == DONE_MAX) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ack is raised on entry so that the RESP cycle is the ack cycle.
        if (rsp_fire) begin
            state_d = RESP;
            if (grant_id_q == PORT_AUX) begin
                p1_ack_d = 1'b1;
                p1_err_d = rsp_err;
                if (rsp_cap) p1_rdata_d = mem_rdata;
            end else begin
                p0_ack_d = 1'b1;
                p0_err_d = rsp_err;
                if (rsp_cap) p0_rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= PORT_AUX;
            grant_id_q   <= 1'b0;
            we_q         <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            p0_err_q     <= 1'b0;
            p1_err_q     <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            we_q         <= we_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            p0_ack_q     <= p0_ack_d;
            p1_ack_q     <= p1_ack_d;
            p0_err_q     <= p0_err_d;
            p1_err_q     <= p1_err_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign p0_err    = p0_err_q;
    assign p1_err    = p1_err_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_spiram_arbiter.sv
// Scoreboard bench: two arbiter instances (round-robin, fixed priority) each
// in front of a small behavioural SPI RAM busy model.
module tb_spiram_arbiter;

    localparam int ST = 8;
    localparam int DT = 100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        p0_req[2], p1_req[2], p0_we[2], p1_we[2];
    logic [15:0] p0_addr[2], p1_addr[2];
    logic [31:0] p0_wdata[2], p1_wdata[2];
    logic        p0_ack[2], p1_ack[2], p0_err[2], p1_err[2];
    logic [31:0] p0_rdata[2], p1_rdata[2];
    logic        mem_rd[2], mem_wr[2], grant_id[2];
    logic [15:0] mem_addr[2];
    logic [31:0] mem_wdata[2], mdata[2];
    logic        rb[2], wb[2];

    spiram_arbiter #(.FIXED_PRIO(0), .START_TIMEOUT(ST), .DONE_TIMEOUT(DT)) dut_rr (
        .clk(clk), .reset(reset),
        .p0_req(p0_req[0]), .p0_we(p0_we[0]), .p0_addr(p0_addr[0]), .p0_wdata(p0_wdata[0]),
        .p0_ack(p0_ack[0]), .p0_rdata(p0_rdata[0]), .p0_err(p0_err[0]),
        .p1_req(p1_req[0]), .p1_we(p1_we[0]), .p1_addr(p1_addr[0]), .p1_wdata(p1_wdata[0]),
        .p1_ack(p1_ack[0]), .p1_rdata(p1_rdata[0]), .p1_err(p1_err[0]),
        .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mdata[0]), .mem_rbusy(rb[0]), .mem_wbusy(wb[0]), .grant_id(grant_id[0])
    );

    spiram_arbiter #(.FIXED_PRIO(1), .START_TIMEOUT(ST), .DONE_TIMEOUT(DT)) dut_fp (
        .clk(clk), .reset(reset),
        .p0_req(p0_req[1]), .p0_we(p0_we[1]), .p0_addr(p0_addr[1]), .p0_wdata(p0_wdata[1]),
        .p0_ack(p0_ack[1]), .p0_rdata(p0_rdata[1]), .p0_err(p0_err[1]),
        .p1_req(p1_req[1]), .p1_we(p1_we[1]), .p1_addr(p1_addr[1]), .p1_wdata(p1_wdata[1]),
        .p1_ack(p1_ack[1]), .p1_rdata(p1_rdata[1]), .p1_err(p1_err[1]),
        .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mdata[1]), .mem_rbusy(rb[1]), .mem_wbusy(wb[1]), .grant_id(grant_id[1])
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    // Busy model: busy rises two negedges after the strobe is seen, lasts blen
    // sampled cycles. bmode 0 = normal, 1 = never busy, 2 = busy forever.
    int   bmode[2], blen[2], bcnt[2], pdly[2];
    logic pkind[2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                rb[d] = 1'b0; wb[d] = 1'b0; pdly[d] = 0; bcnt[d] = 0;
            end else if (mem_rd[d] || mem_wr[d]) begin
                rb[d] = 1'b0; wb[d] = 1'b0; pkind[d] = mem_rd[d]; pdly[d] = 2;
            end else if (pdly[d] != 0) begin
                pdly[d]--;
                if (pdly[d] == 0 && bmode[d] != 1) begin
                    rb[d] = pkind[d]; wb[d] = ~pkind[d]; bcnt[d] = blen[d];
                end
            end else if ((rb[d] || wb[d]) && bmode[d] == 0) begin
                if (bcnt[d] <= 1) begin rb[d] = 1'b0; wb[d] = 1'b0; end
                else bcnt[d]--;
            end
        end
    end

    typedef struct {
        int          dut;
        int          port;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] rd_model[2][2];
    logic        prev_stb[2];

    task automatic expect_txn(input int d, input int port, input logic we, input logic err, input int lat);
        exp_t e;
        if (!we && !err) rd_model[d][port] = mdata[d];
        e.dut = d; e.port = port; e.err = err; e.rdata = rd_model[d][port];
        e.lat = lat; e.t0 = cyc;
        sb_q.push_back(e);
    endtask

    task automatic set_req(input int d, input int port, input logic we, input logic [15:0] addr, input logic [31:0] wd);
        if (port == 0) begin
            p0_req[d] = 1'b1; p0_we[d] = we; p0_addr[d] = addr; p0_wdata[d] = wd;
        end else begin
            p1_req[d] = 1'b1; p1_we[d] = we; p1_addr[d] = addr; p1_wdata[d] = wd;
        end
    endtask

    task automatic wait_ack(input int d, input int port, input bit keep, input int max_cyc);
        bit got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(posedge clk); #1;
            got = (port == 0) ? p0_ack[d] : p1_ack[d];
        end
        if (!got) chk("ack_wait", 32'd0, 32'd1);
        if (!keep) begin
            if (port == 0) p0_req[d] = 1'b0; else p1_req[d] = 1'b0;
        end
    endtask

    task automatic gap();
        @(posedge clk); #1;
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (mem_rd[d] || mem_wr[d]) chk("strobe_width", {31'd0, prev_stb[d]}, 32'd0);
            prev_stb[d] = mem_rd[d] | mem_wr[d];
            for (int p = 0; p < 2; p++) begin
                logic        a, er;
                logic [31:0] rdv;
                a   = (p == 0) ? p0_ack[d]   : p1_ack[d];
                er  = (p == 0) ? p0_err[d]   : p1_err[d];
                rdv = (p == 0) ? p0_rdata[d] : p1_rdata[d];
                if (a) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("ack_owner", d * 2 + p, e.dut * 2 + e.port);
                        chk("ack_err", {31'd0, er}, {31'd0, e.err});
                        chk("ack_rdata", rdv, e.rdata);
                        if (e.lat >= 0) chk("ack_latency", cyc - e.t0, e.lat);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            p0_req[d] = 0; p1_req[d] = 0; p0_we[d] = 0; p1_we[d] = 0;
            p0_addr[d] = 0; p1_addr[d] = 0; p0_wdata[d] = 0; p1_wdata[d] = 0;
            mdata[d] = 0; bmode[d] = 0; blen[d] = 40; prev_stb[d] = 0;
            rd_model[d][0] = 0; rd_model[d][1] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ack", {31'd0, p0_ack[d] | p1_ack[d]}, 32'd0);
            chk("rst_err", {31'd0, p0_err[d] | p1_err[d]}, 32'd0);
            chk("rst_strobe", {31'd0, mem_rd[d] | mem_wr[d]}, 32'd0);
            chk("rst_addr", {16'd0, mem_addr[d]}, 32'd0);
            chk("rst_grant_id", {31'd0, grant_id[d]}, 32'd0);
            chk("rst_rdata", p0_rdata[d] | p1_rdata[d], 32'd0);
        end
        @(negedge clk) reset = 1'b1;

        // Simultaneous requests out of reset, both kept high: p0, p1, p0, p1.
        blen[0] = 5; mdata[0] = 32'hA5A5_0001;
        set_req(0, 0, 1'b0, 16'h0001, 32'd0);
        set_req(0, 1, 1'b0, 16'h0002, 32'd0);
        expect_txn(0, 0, 1'b0, 1'b0, 9);
        expect_txn(0, 1, 1'b0, 1'b0, -1);
        expect_txn(0, 0, 1'b0, 1'b0, -1);
        expect_txn(0, 1, 1'b0, 1'b0, -1);
        wait_ack(0, 0, 1'b1, 100);
        wait_ack(0, 1, 1'b1, 100);
        wait_ack(0, 0, 1'b0, 100);
        wait_ack(0, 1, 1'b0, 100);
        gap();

        // p0 read, 40-cycle busy.
        blen[0] = 40; mdata[0] = 32'hDEAD_BEEF;
        set_req(0, 0, 1'b0, 16'h0012, 32'd0);
        expect_txn(0, 0, 1'b0, 1'b0, 44);
        gap();
        chk("rd_strobe", {31'd0, mem_rd[0]}, 32'd1);
        chk("rd_no_wr", {31'd0, mem_wr[0]}, 32'd0);
        chk("rd_addr", {16'd0, mem_addr[0]}, 32'h0000_0012);
        chk("rd_grant_id", {31'd0, grant_id[0]}, 32'd0);
        gap();
        chk("rd_strobe_low", {31'd0, mem_rd[0]}, 32'd0);
        wait_ack(0, 0, 1'b0, 100);
        gap();

        // p1 write: p1 rdata and all p0 outputs untouched.
        blen[0] = 10; mdata[0] = 32'h0BAD_0BAD;
        set_req(0, 1, 1'b1, 16'hFFFF, 32'h1234_5678);
        expect_txn(0, 1, 1'b1, 1'b0, 14);
        gap();
        chk("wr_strobe", {31'd0, mem_wr[0]}, 32'd1);
        chk("wr_wdata", mem_wdata[0], 32'h1234_5678);
        chk("wr_addr", {16'd0, mem_addr[0]}, 32'h0000_FFFF);
        chk("wr_grant_id", {31'd0, grant_id[0]}, 32'd1);
        wait_ack(0, 1, 1'b0, 100);
        chk("wr_p0_rdata_kept", p0_rdata[0], 32'hDEAD_BEEF);
        chk("wr_p0_ack_quiet", {31'd0, p0_ack[0]}, 32'd0);
        gap();

        // Controller never goes busy.
        bmode[0] = 1;
        set_req(0, 0, 1'b0, 16'h0100, 32'd0);
        expect_txn(0, 0, 1'b0, 1'b1, ST + 3);
        wait_ack(0, 0, 1'b0, 50);
        repeat (3) begin
            gap();
            chk("start_tmo_strobe_low", {31'd0, mem_rd[0] | mem_wr[0]}, 32'd0);
        end

        // Controller stuck busy, then a normal request.
        bmode[0] = 2;
        set_req(0, 1, 1'b0, 16'h0200, 32'd0);
        expect_txn(0, 1, 1'b0, 1'b1, DT + 5);
        wait_ack(0, 1, 1'b0, 200);
        gap();
        bmode[0] = 0; blen[0] = 3; mdata[0] = 32'hCAFE_0003;
        set_req(0, 1, 1'b0, 16'h0300, 32'd0);
        expect_txn(0, 1, 1'b0, 1'b0, 7);
        wait_ack(0, 1, 1'b0, 100);
        gap();

        // Reset during WAIT_DONE, request held across it.
        blen[0] = 40; mdata[0] = 32'h0BAD_F00D;
        set_req(0, 0, 1'b0, 16'h0400, 32'd0);
        expect_txn(0, 0, 1'b0, 1'b0, 44);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ack", {31'd0, p0_ack[0]}, 32'd0);
        chk("mid_rst_strobe", {31'd0, mem_rd[0] | mem_wr[0]}, 32'd0);
        chk("mid_rst_addr", {16'd0, mem_addr[0]}, 32'd0);
        chk("mid_rst_p0_rdata", p0_rdata[0], 32'd0);
        chk("mid_rst_p1_rdata", p1_rdata[0], 32'd0);
        chk("mid_rst_grant_id", {31'd0, grant_id[0]}, 32'd0);
        if (sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
        for (int d = 0; d < 2; d++) begin
            rd_model[d][0] = 0; rd_model[d][1] = 0;
        end
        @(negedge clk) reset = 1'b1;
        expect_txn(0, 0, 1'b0, 1'b0, 44);
        wait_ack(0, 0, 1'b0, 100);
        gap();

        // Fixed priority: p0 renewed twice keeps winning over a held p1.
        blen[1] = 4; mdata[1] = 32'h5555_AAAA;
        set_req(1, 0, 1'b0, 16'h0010, 32'd0);
        set_req(1, 1, 1'b0, 16'h0011, 32'd0);
        expect_txn(1, 0, 1'b0, 1'b0, 8);
        expect_txn(1, 0, 1'b0, 1'b0, -1);
        expect_txn(1, 0, 1'b0, 1'b0, -1);
        expect_txn(1, 1, 1'b0, 1'b0, -1);
        wait_ack(1, 0, 1'b1, 100);
        wait_ack(1, 0, 1'b1, 100);
        wait_ack(1, 0, 1'b0, 100);
        wait_ack(1, 1, 1'b0, 100);

        repeat (5) gap();
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
